// File: rtl/taintcell_pkg.sv
// rtl/taintcell_pkg.sv - shared state encoding, mode names and helpers for the shadow-taint RAM
//
// Purpose : common definitions imported by the scrub FSM and the shadow RAM top.
// Contents: scrub FSM state encoding, MODE name constants, word_nonzero().
package taintcell_pkg;

  // Scrub FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SCRUB = 1'b1;

  // Write-enable taint handling modes
  localparam string MODE_COARSE  = "coarse";
  localparam string MODE_PRECISE = "precise";

  // Widest taint word word_nonzero() can judge; callers zero-extend to this.
  localparam int WORD_MAX = 64;

  function automatic logic word_nonzero(input logic [WORD_MAX-1:0] w);
    return |w;
  endfunction

endpackage

// File: rtl/taintcell_shadow_ram_if.sv
// rtl/taintcell_shadow_ram_if.sv - port bundle of the shadow-taint RAM
//
// Purpose : groups the scrub handshake, read ports, write ports and taint count.
// Modports: master - the instrumented memory side driving requests
//           slave  - the shadow-taint RAM
interface taintcell_shadow_ram_if #(
  parameter int WIDTH    = 8,
  parameter int ABITS    = 4,
  parameter int RD_PORTS = 1,
  parameter int WR_PORTS = 1
) ();

  logic                      SCRUB_REQ;
  logic                      SCRUB_BUSY;
  logic [RD_PORTS-1:0]       RD_EN;
  logic [RD_PORTS-1:0]       RD_EN_taint;
  logic [RD_PORTS*ABITS-1:0] RD_ADDR;
  logic [RD_PORTS*ABITS-1:0] RD_ADDR_taint;
  logic [RD_PORTS*WIDTH-1:0] RD_DATA_taint;
  logic [WR_PORTS*WIDTH-1:0] WR_EN;
  logic [WR_PORTS*WIDTH-1:0] WR_EN_taint;
  logic [WR_PORTS*ABITS-1:0] WR_ADDR;
  logic [WR_PORTS*ABITS-1:0] WR_ADDR_taint;
  logic [WR_PORTS*WIDTH-1:0] WR_DATA_taint;
  logic [ABITS:0]            taint_sum;

  modport master (
    output SCRUB_REQ,
    output RD_EN, RD_EN_taint, RD_ADDR, RD_ADDR_taint,
    output WR_EN, WR_EN_taint, WR_ADDR, WR_ADDR_taint, WR_DATA_taint,
    input  SCRUB_BUSY, RD_DATA_taint, taint_sum
  );

  modport slave (
    input  SCRUB_REQ,
    input  RD_EN, RD_EN_taint, RD_ADDR, RD_ADDR_taint,
    input  WR_EN, WR_EN_taint, WR_ADDR, WR_ADDR_taint, WR_DATA_taint,
    output SCRUB_BUSY, RD_DATA_taint, taint_sum
  );

endinterface

// File: rtl/taintcell_scrub_fsm.sv
// rtl/taintcell_scrub_fsm.sv - scrub sequencer that clears the taint array one word per cycle
//
// Purpose : walks a pointer over 0..SIZE-1 after reset or on request.
// Ports   : CLK, RST       - clock, asynchronous active-high reset
//           i_scrub_req    - single-cycle scrub request (ignored while scrubbing)
//           o_busy         - registered decode of the SCRUB state
//           o_block        - ports must be ignored this cycle (scrubbing or request edge)
//           o_clr_en       - clear word o_clr_idx at this edge
//           o_clr_idx      - word being cleared
module taintcell_scrub_fsm
  import taintcell_pkg::*;
#(
  parameter int ABITS = 4,
  parameter int SIZE  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_scrub_req,
  output logic             o_busy,
  output logic             o_block,
  output logic             o_clr_en,
  output logic [ABITS-1:0] o_clr_idx
);

  localparam logic [ABITS-1:0] LAST_IDX = ABITS'(SIZE - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [ABITS-1:0] r_ptr;
  logic [ABITS-1:0] w_ptr_nxt;
  logic             r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_SCRUB: begin
        if (r_ptr == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ABITS'(1);
        end
      end
      default: begin
        if (i_scrub_req) begin
          w_state_nxt = ST_SCRUB;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_SCRUB;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      // Busy follows the state register exactly, but is its own flop so
      // the output carries no decode logic.
      r_busy  <= (w_state_nxt == ST_SCRUB);
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_en  = (r_state == ST_SCRUB);
  assign o_clr_idx = r_ptr;
  // The request edge itself already belongs to the scrub: ports are dropped there.
  assign o_block   = (r_state == ST_SCRUB) || i_scrub_req;

endmodule

// File: rtl/taintcell_shadow_ram.sv
// rtl/taintcell_shadow_ram.sv - shadow-taint RAM with taint propagation and tainted-word count
//
// Purpose : one taint bit per data bit of a multi-port synchronous memory.
//           Propagates taint through reads and writes, keeps an incremental
//           count of tainted words, and scrubs itself after reset or request.
// Ports   : CLK, RST - clock, asynchronous active-high reset
//           bus      - taintcell_shadow_ram_if.slave (scrub handshake,
//                      RD_* read ports, WR_* write ports, taint_sum)
module taintcell_shadow_ram
  import taintcell_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    ABITS    = 4,
  parameter int    SIZE     = 16,
  parameter int    OFFSET   = 0,
  parameter int    RD_PORTS = 1,
  parameter int    WR_PORTS = 1,
  parameter string MODE     = MODE_COARSE
) (
  input logic                   CLK,
  input logic                   RST,
  taintcell_shadow_ram_if.slave bus
);

  localparam bit               PRECISE = (MODE == MODE_PRECISE);
  localparam logic [ABITS-1:0] OFF     = ABITS'(OFFSET);
  localparam logic [ABITS:0]   SIZE_L  = (ABITS+1)'(SIZE);

  logic                      w_block;
  logic                      w_clr_en;
  logic                      w_busy;
  logic [ABITS-1:0]          w_clr_idx;

  // Storage has no reset: it is cleared by the scrub sequencer instead.
  logic [WIDTH-1:0]          r_mem [SIZE];

  logic [ABITS-1:0]          w_wr_idx [WR_PORTS];
  logic [WR_PORTS-1:0]       w_wr_ok;
  logic [WIDTH-1:0]          w_rd_val [RD_PORTS];
  logic [WIDTH-1:0]          w_new [SIZE];
  logic [SIZE-1:0]           w_hit;
  logic [ABITS:0]            w_inc;
  logic [ABITS:0]            w_dec;
  logic [ABITS:0]            r_sum;
  logic [RD_PORTS*WIDTH-1:0] r_rd;

  taintcell_scrub_fsm #(
    .ABITS (ABITS),
    .SIZE  (SIZE)
  ) u_scrub (
    .CLK         (CLK),
    .RST         (RST),
    .i_scrub_req (bus.SCRUB_REQ),
    .o_busy      (w_busy),
    .o_block     (w_block),
    .o_clr_en    (w_clr_en),
    .o_clr_idx   (w_clr_idx)
  );

  // Write index decode; subtraction wraps modulo 2^ABITS.
  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      w_wr_idx[p] = bus.WR_ADDR[p*ABITS +: ABITS] - OFF;
      w_wr_ok[p]  = ({1'b0, w_wr_idx[p]} < SIZE_L);
    end
  end

  // Read mux: an index that matches no stored word is out of range and
  // reads as fully tainted.
  always_comb begin : p_rd_mux
    logic [ABITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      idx         = bus.RD_ADDR[i*ABITS +: ABITS] - OFF;
      w_rd_val[i] = '1;
      for (int k = 0; k < SIZE; k++) begin
        if (idx == ABITS'(k)) begin
          w_rd_val[i] = r_mem[k] | {WIDTH{|bus.RD_ADDR_taint[i*ABITS +: ABITS]}};
        end
      end
    end
  end

  // Per-word write merge. Ports are folded in ascending order so the highest
  // port owns each enabled bit; in precise mode every port's enable taint is
  // also ORed in, since any of those writes might have happened.
  always_comb begin : p_merge
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] et;
    logic [WIDTH-1:0] d;
    w_hit = '0;
    v     = '0;
    acc   = '0;
    en    = '0;
    et    = '0;
    d     = '0;
    for (int k = 0; k < SIZE; k++) begin
      v   = r_mem[k];
      acc = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        en = bus.WR_EN[p*WIDTH +: WIDTH];
        et = bus.WR_EN_taint[p*WIDTH +: WIDTH];
        d  = bus.WR_DATA_taint[p*WIDTH +: WIDTH] |
             {WIDTH{|bus.WR_ADDR_taint[p*ABITS +: ABITS]}};
        if (!w_block && w_wr_ok[p] && (w_wr_idx[p] == ABITS'(k))) begin
          w_hit[k] = 1'b1;
          if (PRECISE) begin
            v   = (v & ~en) | (d & en);
            acc = acc | et;
          end else if (|et) begin
            v = '1;
          end else begin
            v = (v & ~en) | (d & en);
          end
        end
      end
      w_new[k] = v | acc;
    end
  end

  // Incremental count: only words written this cycle can change state, and
  // each is judged once on its merged value.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (w_hit[k]) begin
        if (!word_nonzero(WORD_MAX'(r_mem[k])) && word_nonzero(WORD_MAX'(w_new[k]))) begin
          w_inc = w_inc + (ABITS+1)'(1);
        end
        if (word_nonzero(WORD_MAX'(r_mem[k])) && !word_nonzero(WORD_MAX'(w_new[k]))) begin
          w_dec = w_dec + (ABITS+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < SIZE; k++) begin
      if (w_clr_en && (w_clr_idx == ABITS'(k))) begin
        r_mem[k] <= '0;
      end else if (w_hit[k]) begin
        r_mem[k] <= w_new[k];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum <= '0;
    end else if (w_block) begin
      r_sum <= '0;
    end else begin
      r_sum <= r_sum + w_inc - w_dec;
    end
  end

  // Read registers sample the array before this edge's writes (read-first).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd <= '0;
    end else begin
      for (int i = 0; i < RD_PORTS; i++) begin
        if (w_block) begin
          if (bus.RD_EN[i] || bus.RD_EN_taint[i]) begin
            r_rd[i*WIDTH +: WIDTH] <= '0;
          end
        end else if (bus.RD_EN_taint[i]) begin
          r_rd[i*WIDTH +: WIDTH] <= '1;
        end else if (bus.RD_EN[i]) begin
          r_rd[i*WIDTH +: WIDTH] <= w_rd_val[i];
        end
      end
    end
  end

  assign bus.RD_DATA_taint = r_rd;
  assign bus.taint_sum     = r_sum;
  assign bus.SCRUB_BUSY    = w_busy;

endmodule

// File: tb/tb_taintcell_shadow_ram.sv
// tb/tb_taintcell_shadow_ram.sv - directed self-checking bench for taintcell_shadow_ram
module tb_taintcell_shadow_ram;

  logic CLK;
  logic RST;

  taintcell_shadow_ram_if #(.WIDTH(8), .ABITS(4), .RD_PORTS(1), .WR_PORTS(2)) ia ();
  taintcell_shadow_ram_if #(.WIDTH(8), .ABITS(4), .RD_PORTS(1), .WR_PORTS(1)) ib ();

  // Coarse, full-size, two write ports
  taintcell_shadow_ram #(
    .WIDTH(8), .ABITS(4), .SIZE(16), .OFFSET(0),
    .RD_PORTS(1), .WR_PORTS(2), .MODE("coarse")
  ) u_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ia)
  );

  // Precise, 12 words at offset 2 so indices 12..15 are out of range
  taintcell_shadow_ram #(
    .WIDTH(8), .ABITS(4), .SIZE(12), .OFFSET(2),
    .RD_PORTS(1), .WR_PORTS(1), .MODE("precise")
  ) u_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ib)
  );

  typedef struct {
    bit         b;
    string      tag;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    ia.SCRUB_REQ = 1'b0; ia.RD_EN = '0; ia.RD_EN_taint = '0; ia.RD_ADDR_taint = '0;
    ia.WR_EN = '0; ia.WR_EN_taint = '0; ia.WR_DATA_taint = '0; ia.WR_ADDR_taint = '0;
    ib.SCRUB_REQ = 1'b0; ib.RD_EN = '0; ib.RD_EN_taint = '0; ib.RD_ADDR_taint = '0;
    ib.WR_EN = '0; ib.WR_EN_taint = '0; ib.WR_DATA_taint = '0; ib.WR_ADDR_taint = '0;
  endtask

  // One clock: outputs are sampled 1ns after the edge, pending reads popped
  // from the scoreboard, then single-cycle strobes are dropped.
  task automatic tick();
    rd_exp_t e;
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 16'(e.b ? ib.RD_DATA_taint : ia.RD_DATA_taint), 16'(e.exp));
    end
    clr_inputs();
  endtask

  task automatic rd(input bit b, input logic [3:0] addr, input logic [3:0] at,
                    input logic en, input logic et, input logic [7:0] exp, input string tag);
    rd_exp_t e;
    if (b) begin
      ib.RD_EN = en; ib.RD_EN_taint = et; ib.RD_ADDR = addr; ib.RD_ADDR_taint = at;
    end else begin
      ia.RD_EN = en; ia.RD_EN_taint = et; ia.RD_ADDR = addr; ia.RD_ADDR_taint = at;
    end
    e.b = b; e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic wr(input bit b, input int p, input logic [3:0] addr, input logic [3:0] at,
                    input logic [7:0] en, input logic [7:0] et, input logic [7:0] dt);
    if (b) begin
      ib.WR_ADDR = addr; ib.WR_ADDR_taint = at;
      ib.WR_EN = en; ib.WR_EN_taint = et; ib.WR_DATA_taint = dt;
    end else begin
      ia.WR_ADDR[p*4 +: 4] = addr; ia.WR_ADDR_taint[p*4 +: 4] = at;
      ia.WR_EN[p*8 +: 8] = en; ia.WR_EN_taint[p*8 +: 8] = et; ia.WR_DATA_taint[p*8 +: 8] = dt;
    end
  endtask

  initial begin
    int ca;
    int cb;
    RST = 1'b1;
    clr_inputs();
    ia.RD_ADDR = '0; ia.WR_ADDR = '0;
    ib.RD_ADDR = '0; ib.WR_ADDR = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy_a", 16'(ia.SCRUB_BUSY), 16'd1);
    check("rst_busy_b", 16'(ib.SCRUB_BUSY), 16'd1);
    check("rst_sum_a", 16'(ia.taint_sum), 16'd0);
    check("rst_rd_a", 16'(ia.RD_DATA_taint), 16'd0);
    RST = 1'b0;

    // Initial scrub length
    ca = 0; cb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ia.SCRUB_BUSY && !ib.SCRUB_BUSY) break;
      if (ia.SCRUB_BUSY) ca++;
      if (ib.SCRUB_BUSY) cb++;
      tick();
    end
    check("init_scrub_len_a", 16'(ca), 16'd16);
    check("init_scrub_len_b", 16'(cb), 16'd12);

    // Whole array clean; B addresses 0,1,14,15 map outside its 12 words
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, 4'(i), 4'h0, 1'b1, 1'b0, 8'h00, $sformatf("init_rd_a%0d", i));
      rd(1'b1, 4'(i), 4'h0, 1'b1, 1'b0, (i < 2 || i > 13) ? 8'hFF : 8'h00,
         $sformatf("init_rd_b%0d", i));
      tick();
    end
    check("init_sum_a", 16'(ia.taint_sum), 16'd0);
    check("init_sum_b", 16'(ib.taint_sum), 16'd0);

    // Coarse plain write and rewrite
    wr(1'b0, 0, 4'd3, 4'h0, 8'hFF, 8'h00, 8'h05); tick();
    check("wr3_sum", 16'(ia.taint_sum), 16'd1);
    rd(1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 8'h05, "rd3"); tick();
    wr(1'b0, 0, 4'd3, 4'h0, 8'hFF, 8'h00, 8'h00); tick();
    check("clr3_sum", 16'(ia.taint_sum), 16'd0);
    rd(1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 8'h00, "rd3_clean"); tick();

    // Address taint on write and read, read-enable taint, hold
    wr(1'b0, 0, 4'd5, 4'h1, 8'hFF, 8'h00, 8'h00); tick();
    check("wr5_at_sum", 16'(ia.taint_sum), 16'd1);
    rd(1'b0, 4'd5, 4'h0, 1'b1, 1'b0, 8'hFF, "rd5_addr_taint_wr"); tick();
    rd(1'b0, 4'd7, 4'h2, 1'b1, 1'b0, 8'hFF, "rd7_addr_taint_rd"); tick();
    rd(1'b0, 4'd7, 4'h0, 1'b1, 1'b0, 8'h00, "rd7_clean"); tick();
    rd(1'b0, 4'd7, 4'h0, 1'b0, 1'b1, 8'hFF, "rd7_en_taint"); tick();
    rd(1'b0, 4'd7, 4'h0, 1'b1, 1'b0, 8'h00, "rd7_clean2"); tick();
    rd(1'b0, 4'd5, 4'h0, 1'b0, 1'b0, 8'h00, "rd_hold"); tick();

    // Read-first: read and write the same word in one cycle
    wr(1'b0, 0, 4'd7, 4'h0, 8'hFF, 8'h00, 8'h42);
    rd(1'b0, 4'd7, 4'h0, 1'b1, 1'b0, 8'h00, "rd_first_old"); tick();
    rd(1'b0, 4'd7, 4'h0, 1'b1, 1'b0, 8'h42, "rd_first_new"); tick();
    wr(1'b0, 0, 4'd7, 4'h0, 8'hFF, 8'h00, 8'h00); tick();

    // Enable-taint handling: coarse vs precise on old word 0x80
    wr(1'b0, 0, 4'd9,  4'h0, 8'hFF, 8'h00, 8'h80);
    wr(1'b1, 0, 4'd11, 4'h0, 8'hFF, 8'h00, 8'h80); tick();
    check("prec_pre_sum_b", 16'(ib.taint_sum), 16'd1);
    wr(1'b0, 0, 4'd9,  4'h0, 8'h0F, 8'h30, 8'h01);
    wr(1'b1, 0, 4'd11, 4'h0, 8'h0F, 8'h30, 8'h01); tick();
    rd(1'b0, 4'd9,  4'h0, 1'b1, 1'b0, 8'hFF, "coarse_en_taint");
    rd(1'b1, 4'd11, 4'h0, 1'b1, 1'b0, 8'hB1, "precise_en_taint"); tick();
    check("sum_a_two", 16'(ia.taint_sum), 16'd2);

    // Out-of-range write on B is dropped
    wr(1'b1, 0, 4'd0, 4'h0, 8'hFF, 8'h00, 8'hFF); tick();
    check("oor_wr_sum_b", 16'(ib.taint_sum), 16'd1);

    // Two ports, same word: highest port wins on enabled bits
    wr(1'b0, 0, 4'd2, 4'h0, 8'hFF, 8'h00, 8'h0F);
    wr(1'b0, 1, 4'd2, 4'h0, 8'hFF, 8'h00, 8'h00); tick();
    check("dual_same_sum", 16'(ia.taint_sum), 16'd2);
    rd(1'b0, 4'd2, 4'h0, 1'b1, 1'b0, 8'h00, "dual_same_rd"); tick();
    wr(1'b0, 0, 4'd4, 4'h0, 8'hFF, 8'h00, 8'h0F);
    wr(1'b0, 1, 4'd4, 4'h0, 8'hF0, 8'h00, 8'h30); tick();
    check("dual_part_sum", 16'(ia.taint_sum), 16'd3);
    rd(1'b0, 4'd4, 4'h0, 1'b1, 1'b0, 8'h3F, "dual_part_rd"); tick();

    // Two distinct words in one cycle: +2, then -1 with a no-op on the other port
    wr(1'b0, 0, 4'd6, 4'h0, 8'hFF, 8'h00, 8'h01);
    wr(1'b0, 1, 4'd8, 4'h0, 8'hFF, 8'h00, 8'h02); tick();
    check("dual_inc2_sum", 16'(ia.taint_sum), 16'd5);
    wr(1'b0, 0, 4'd9,  4'h0, 8'hFF, 8'h00, 8'h00);
    wr(1'b0, 1, 4'd12, 4'h0, 8'hFF, 8'h00, 8'h00); tick();
    check("dual_dec_sum", 16'(ia.taint_sum), 16'd4);

    // Scrub request with a write on the request edge
    ia.SCRUB_REQ = 1'b1;
    ib.SCRUB_REQ = 1'b1;
    wr(1'b0, 0, 4'd0, 4'h0, 8'hFF, 8'h00, 8'hFF); tick();
    check("req_sum_a", 16'(ia.taint_sum), 16'd0);
    check("req_busy_a", 16'(ia.SCRUB_BUSY), 16'd1);
    ca = 0; cb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ia.SCRUB_BUSY && !ib.SCRUB_BUSY) break;
      if (ia.SCRUB_BUSY) ca++;
      if (ib.SCRUB_BUSY) cb++;
      if (i == 2) begin
        wr(1'b0, 0, 4'd1, 4'h0, 8'hFF, 8'h00, 8'hFF);
        rd(1'b0, 4'd4, 4'h0, 1'b1, 1'b0, 8'h00, "scrub_rd");
        ia.SCRUB_REQ = 1'b1;
      end
      if (i == 5) check("scrub_sum_a", 16'(ia.taint_sum), 16'd0);
      tick();
    end
    check("req_scrub_len_a", 16'(ca), 16'd16);
    check("req_scrub_len_b", 16'(cb), 16'd12);
    check("post_scrub_sum_a", 16'(ia.taint_sum), 16'd0);
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, 4'(i), 4'h0, 1'b1, 1'b0, 8'h00, $sformatf("post_rd_a%0d", i));
      tick();
    end
    rd(1'b1, 4'd11, 4'h0, 1'b1, 1'b0, 8'h00, "post_rd_b11"); tick();

    // Normal operation resumes
    wr(1'b0, 0, 4'd1, 4'h0, 8'hFF, 8'h00, 8'h01); tick();
    check("resume_sum_a", 16'(ia.taint_sum), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
